// File: rtl/axis_line_packer.sv
// rtl/axis_line_packer.sv - packs a 32-bit AXI-Stream word stream into wide BRAM lines
// Lines close on a full buffer or on tlast; a held line retires and a new beat lands in the same cycle.
module axis_line_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 36,
  parameter int CNT_WIDTH      = 6,
  localparam int LINE_WIDTH    = DATA_WIDTH * WORDS_PER_LINE,
  localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [STRB_WIDTH-1:0] s00_axis_tstrb,
  input  logic                  s00_axis_tlast,
  input  logic                  s00_axis_tvalid,
  output logic                  s00_axis_tready,
  output logic [LINE_WIDTH-1:0] line_data,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic                  line_last,
  output logic                  line_partial,
  output logic [CNT_WIDTH-1:0]  line_words,
  output logic                  strb_err,
  output logic [15:0]           line_count
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_SLOT  = CNT_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_WORDS = CNT_WIDTH'(WORDS_PER_LINE);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic [DATA_WIDTH-1:0]  masked;
  logic                   accept;
  logic                   handoff;
  logic                   strb_full;

  always_comb begin
    masked = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      masked[b*8 +: 8] = s00_axis_tstrb[b] ? s00_axis_tdata[b*8 +: 8] : 8'h00;
    end
  end

  // Ready follows the consumer while holding so retire and refill share one edge.
  assign s00_axis_tready = (state == FILL) | line_ready;
  assign line_valid      = (state == HOLD);
  assign accept          = s00_axis_tvalid & s00_axis_tready;
  assign handoff         = (state == HOLD) & line_ready;
  assign strb_full       = &s00_axis_tstrb;
  assign cnt_next        = cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      cnt          <= '0;
      line_data    <= '0;
      line_last    <= 1'b0;
      line_partial <= 1'b0;
      line_words   <= '0;
      strb_err     <= 1'b0;
      line_count   <= '0;
    end else begin
      if (accept && !strb_full) begin
        strb_err <= 1'b1;
      end
      if (handoff) begin
        line_count <= line_count + 16'd1;
      end
      case (state)
        FILL: begin
          if (accept) begin
            line_data[int'(cnt)*DATA_WIDTH +: DATA_WIDTH] <= masked;
            if (cnt == LAST_SLOT || s00_axis_tlast) begin
              state        <= HOLD;
              cnt          <= '0;
              line_words   <= cnt_next;
              line_last    <= s00_axis_tlast;
              line_partial <= (cnt_next != FULL_WORDS);
            end else begin
              cnt <= cnt_next;
            end
          end
        end
        HOLD: begin
          if (handoff) begin
            if (accept) begin
              // The retiring line is replaced wholesale so stale slots read as zero.
              line_data <= LINE_WIDTH'(masked);
              if (s00_axis_tlast || WORDS_PER_LINE == 1) begin
                state        <= HOLD;
                cnt          <= '0;
                line_words   <= CNT_WIDTH'(1);
                line_last    <= s00_axis_tlast;
                line_partial <= (WORDS_PER_LINE > 1);
              end else begin
                state <= FILL;
                cnt   <= CNT_WIDTH'(1);
              end
            end else begin
              state     <= FILL;
              cnt       <= '0;
              line_data <= '0;
            end
          end
        end
        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_line_packer.sv
// tb/tb_axis_line_packer.sv - directed and randomized checks of axis_line_packer against a line-list model
// The model groups accepted beats into lines by count and tlast; observed handoffs are queued and compared.
module tb_axis_line_packer;

  localparam int DW = 32;
  localparam int WPL = 36;
  localparam int LW = DW * WPL;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s00_axis_tdata;
  logic [3:0]    s00_axis_tstrb;
  logic          s00_axis_tlast;
  logic          s00_axis_tvalid;
  logic          s00_axis_tready;
  logic [LW-1:0] line_data;
  logic          line_valid;
  logic          line_ready;
  logic          line_last;
  logic          line_partial;
  logic [5:0]    line_words;
  logic          strb_err;
  logic [15:0]   line_count;

  axis_line_packer dut (
    .clk(clk), .rst(rst),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tstrb(s00_axis_tstrb),
    .s00_axis_tlast(s00_axis_tlast), .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tready(s00_axis_tready),
    .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
    .line_last(line_last), .line_partial(line_partial), .line_words(line_words),
    .strb_err(strb_err), .line_count(line_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LW-1:0] data;
    int            words;
    logic          last;
    logic          partial;
  } line_t;

  line_t         exp_q[$];
  line_t         obs_q[$];
  line_t         hist[$];
  logic [DW-1:0] acc_words[WPL];
  int            acc_n;
  logic [15:0]   exp_handoffs;
  logic          exp_strb_err;
  int            stall_cycles;
  int            lr_mode;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic [3:0] s, input logic l);
    line_t ln;
    logic [DW-1:0] w;
    for (int b = 0; b < 4; b++) w[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
    if (s != 4'hF) exp_strb_err = 1'b1;
    acc_words[acc_n] = w;
    acc_n++;
    if (acc_n == WPL || l) begin
      ln.data = '0;
      for (int k = 0; k < acc_n; k++) ln.data[k*DW +: DW] = acc_words[k];
      ln.words   = acc_n;
      ln.last    = l;
      ln.partial = (acc_n < WPL);
      exp_q.push_back(ln);
      acc_n = 0;
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic [3:0] s, input logic l,
                      output logic acc);
    line_t o;
    s00_axis_tvalid = v;
    s00_axis_tdata  = d;
    s00_axis_tstrb  = s;
    s00_axis_tlast  = l;
    line_ready = (lr_mode == 0) ? 1'b1 : (lr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    acc = v && s00_axis_tready;
    if (v && !s00_axis_tready) stall_cycles++;
    if (acc) model_accept(d, s, l);
    if (line_valid && line_ready) begin
      o.data = line_data; o.words = int'(line_words);
      o.last = line_last; o.partial = line_partial;
      obs_q.push_back(o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic a;
    step(1'b0, '0, 4'hF, 1'b0, a);
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] s, input logic l);
    logic a;
    int n;
    a = 1'b0;
    n = 0;
    while (!a && n < 200) begin
      step(1'b1, d, s, l, a);
      n++;
    end
    if (!a) chk("send_timeout", LW'(a), LW'(1));
  endtask

  task automatic drain();
    int n;
    lr_mode = 0;
    n = 0;
    while (line_valid && n < 100) begin
      idle();
      n++;
    end
    idle();
    chk("drain_timeout", LW'(line_valid), LW'(0));
  endtask

  task automatic check_lines();
    line_t o, e;
    chk("line_qty", LW'(obs_q.size()), LW'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk("line_data", o.data, e.data);
      chk("line_words", LW'(o.words), LW'(e.words));
      chk("line_last", LW'(o.last), LW'(e.last));
      chk("line_partial", LW'(o.partial), LW'(e.partial));
      hist.push_back(o);
      exp_handoffs++;
    end
    obs_q.delete();
    exp_q.delete();
    chk("line_count", LW'(line_count), LW'(exp_handoffs));
    chk("strb_err", LW'(strb_err), LW'(exp_strb_err));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    acc_n = 0;
    exp_handoffs = '0;
    exp_strb_err = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  logic [LW-1:0] held;
  logic [LW-1:0] tmp;
  logic [DW-1:0] w;

  initial begin
    s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tstrb = 4'hF;
    s00_axis_tlast = 1'b0; line_ready = 1'b1; lr_mode = 0; stall_cycles = 0;
    @(posedge clk);
    #1;
    do_reset();

    chk("rst_line_valid", LW'(line_valid), LW'(0));
    chk("rst_line_count", LW'(line_count), LW'(0));
    chk("rst_tready", LW'(s00_axis_tready), LW'(1));
    chk("rst_line_data", line_data, '0);
    chk("rst_line_words", LW'(line_words), LW'(0));
    chk("rst_strb_err", LW'(strb_err), LW'(0));

    // full line, alternating pattern, tlast on the final slot
    for (int i = 0; i < WPL; i++) send_beat((i % 2 == 0) ? 32'hAAAAAAAA : 32'hCCCCCCCC, 4'hF, i == WPL - 1);
    drain();
    check_lines();
    tmp = {18{32'hCCCCCCCC, 32'hAAAAAAAA}};
    if (hist.size() > 0) chk("full_pattern", hist[hist.size()-1].data, tmp);
    chk("full_no_stall", LW'(stall_cycles), LW'(0));

    // partial line of five words
    for (int i = 1; i <= 5; i++) send_beat(DW'(i), 4'hF, i == 5);
    drain();
    check_lines();
    tmp = LW'({32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
    if (hist.size() > 0) chk("partial_data", hist[hist.size()-1].data, tmp);

    // backpressure: full line held for 10 cycles with the next beat waiting
    lr_mode = 2;
    for (int i = 0; i < WPL; i++) send_beat($urandom, 4'hF, 1'b0);
    held = exp_q[exp_q.size()-1].data;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", LW'(line_valid), LW'(1));
      chk("bp_tready", LW'(s00_axis_tready), LW'(0));
      chk("bp_stable", line_data, held);
      begin
        logic a;
        step(1'b1, 32'hFEEDF00D, 4'hF, 1'b0, a);
      end
    end
    lr_mode = 0;
    send_beat(32'hFEEDF00D, 4'hF, 1'b0);
    for (int i = 1; i < WPL; i++) send_beat($urandom, 4'hF, 1'b0);
    drain();
    check_lines();

    // back-to-back: 72 continuous beats with an always-ready consumer
    stall_cycles = 0;
    hist.delete();
    for (int i = 0; i < 2 * WPL; i++) send_beat(32'h1000_0000 + DW'(i + 1), 4'hF, 1'b0);
    drain();
    check_lines();
    chk("b2b_no_stall", LW'(stall_cycles), LW'(0));
    if (hist.size() > 1) chk("b2b_slot0", LW'(hist[1].data[DW-1:0]), LW'(32'h1000_0025));
    else chk("b2b_lines", LW'(hist.size()), LW'(2));

    // byte strobes
    send_beat(32'h12345678, 4'b0101, 1'b1);
    drain();
    check_lines();
    if (hist.size() > 0) chk("strb_slot", LW'(hist[hist.size()-1].data[DW-1:0]), LW'(32'h00340078));
    chk("strb_err_set", LW'(strb_err), LW'(1));

    // random traffic with random gaps, strobes, tlast and consumer stalls
    lr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      w = $urandom;
      send_beat(w, ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF, $urandom_range(0, 11) == 0);
    end
    send_beat(32'hC0DE0001, 4'hF, 1'b1);
    drain();
    check_lines();
    chk("strb_err_sticky", LW'(strb_err), LW'(1));

    // reset in the middle of a line
    for (int i = 0; i < 20; i++) send_beat($urandom, 4'hF, 1'b0);
    do_reset();
    chk("mid_rst_valid", LW'(line_valid), LW'(0));
    chk("mid_rst_count", LW'(line_count), LW'(0));
    chk("mid_rst_strb", LW'(strb_err), LW'(0));
    hist.delete();
    for (int i = 0; i < WPL; i++) send_beat(32'hBEEF_0000 + DW'(i), 4'hF, 1'b0);
    drain();
    check_lines();
    if (hist.size() > 0) chk("post_rst_slot0", LW'(hist[0].data[DW-1:0]), LW'(32'hBEEF_0000));
    else chk("post_rst_lines", LW'(hist.size()), LW'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/axis_line_packer.md
Name: axis_line_packer

Overview:
- AXI-Stream slave that receives the 32-bit word stream produced by the BRAM adapter in read mode (m00 side), or by any equivalent source.
- Packs WORDS_PER_LINE consecutive beats into one 1152-bit line, the BRAM line width, and presents it on a valid/ready line port to the downstream compute or compare stage.
- Handles partial lines terminated by tlast, byte strobes, and backpressure in both directions.
- Sustains one beat per cycle when the line consumer is always ready.

Parameters:
- DATA_WIDTH, 32, stream word width in bits; must be a multiple of 8.
- WORDS_PER_LINE, 36, beats per line.
- LINE_WIDTH, DATA_WIDTH*WORDS_PER_LINE (1152), line width; derived, never overridden.
- CNT_WIDTH, 6, word-counter width; must satisfy 2**CNT_WIDTH > WORDS_PER_LINE.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s00_axis_tdata  in  DATA_WIDTH  stream word.
- s00_axis_tstrb  in  DATA_WIDTH/8  byte strobes.
- s00_axis_tlast  in  1  last beat of frame.
- s00_axis_tvalid  in  1  beat valid.
- s00_axis_tready  out  1  beat accepted when tvalid&tready.
- line_data  out  LINE_WIDTH  packed line; word k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- line_valid  out  1  line available.
- line_ready  in  1  consumer takes line when line_valid&line_ready.
- line_last  out  1  line ended by tlast.
- line_partial  out  1  line holds fewer than WORDS_PER_LINE words.
- line_words  out  CNT_WIDTH  number of valid words in line (1..WORDS_PER_LINE).
- strb_err  out  1  sticky: some accepted beat had tstrb not all-ones.
- line_count  out  16  lines handed off since reset; wraps at 65535->0.

Behaviour:
- Reset is synchronous, active-high, sampled on clk.
- Reset values: state=FILL, word counter=0, buffer=0, line_data=0, line_valid=0, line_last=0, line_partial=0, line_words=0, strb_err=0, line_count=0. s00_axis_tready=1 in the cycle after reset deasserts.
- Reset mid-line or while a line is held: the partial line and held line are discarded with no handoff; all state returns to the reset values.
- States:
  - FILL: accumulating words; line_valid=0.
  - HOLD: line complete; line_valid=1 and outputs stable until handoff.
- s00_axis_tready = (state==FILL) | line_ready. It is combinational from line_ready only and never depends on tvalid.
- Accept in FILL at counter k:
  - Byte b of slot k gets tdata byte b if tstrb[b]=1, else 0.
  - If k==WORDS_PER_LINE-1 or tlast=1: go to HOLD with line_words=k+1, line_last=tlast, line_partial=(k+1<WORDS_PER_LINE), counter=0.
  - Otherwise counter=k+1.
- Slots not written in a partial line read as 0; the buffer is cleared at every line start.
- Handoff: on line_valid&line_ready, line_count increments the same edge.
- Handoff with simultaneous accept (HOLD, line_ready=1, tvalid=1):
  - The held line retires.
  - The new beat goes to slot 0 of a cleared buffer.
  - Next state is FILL with counter=1, or HOLD again if that beat has tlast=1 or WORDS_PER_LINE=1.
  - No bubble occurs.
- Handoff without a beat: next state FILL, counter=0, buffer cleared.
- Latency: the beat completing a line is accepted at edge N; line_valid=1 after edge N.
- tlast on the final slot gives line_last=1, line_partial=0.
- tlast is not required at line boundaries; frames may span many lines.
- tvalid=0 cycles are ignored; no timeout.
- strb_err sets on any accepted beat with tstrb != all-ones and clears only on rst.
- line_data, line_last, line_partial and line_words hold stable while line_valid=1 and line_ready=0.

Test Plan:
- Full line: 36 beats alternating 32'hAAAAAAAA/32'hCCCCCCCC, tstrb=4'hF, tlast on beat 36, line_ready=1 -> one line {18{32'hCCCCCCCC,32'hAAAAAAAA}}, line_last=1, line_partial=0, line_words=36, line_count=1, tready never drops.
- Partial: 5 beats 1..5 with tlast on beat 5 -> line_data[159:0] = words 1..5 (word 1 at bits 31:0), upper bits 0, line_words=5, line_partial=1, line_last=1.
- Backpressure: line_ready=0 for 10 cycles after a full line -> line_valid and data stable, tready=0, no beat lost; 36 more beats after release -> second line correct, line_count=2.
- Back-to-back: 72 beats continuous, line_ready=1 -> two lines, zero tready-low cycles, second line slot 0 = beat 37.
- Strobe: beat 32'h12345678 with tstrb=4'b0101 -> slot holds 32'h00340078, strb_err=1 and stays 1 through later lines.
- Reset mid-line: assert rst after 20 beats -> line_valid=0, line_count=0; next 36 beats form a clean line with slot 0 = first post-reset beat.
